// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO and its read-side controller.
// The count width carries one extra bit so a completely full FIFO is representable.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer carrying {data, last}; absorbs the FIFO read pipeline
// so the downstream stream can stall without losing in-flight words.
module fifo_skid_buf #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             push_last,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [width-1:0] pop_data,
    output logic             pop_last,
    output logic [1:0]       count
);

    logic [width:0] mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic           do_pop;

    assign pop_valid            = (count != 2'd0);
    assign do_pop               = pop_valid && pop_ready;
    assign {pop_data, pop_last} = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_data, push_last};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            // simultaneous push and pop leaves occupancy unchanged
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side controller: drains the FIFO in packets of `burst` words (or a shorter
// flush after `timeout` idle cycles) onto a valid/ready stream with out_last framing.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int width   = 8,
    parameter int depth   = 16,
    parameter int burst   = 4,
    parameter int timeout = 15,
    localparam int CW     = cnt_width(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [CW-1:0]    fifo_count,
    input  logic [width-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int            TW          = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam logic [CW-1:0] BURST_LEN   = CW'(burst);
    localparam logic [CW-1:0] ONE         = CW'(1);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(timeout);

    rd_state_t     state;
    logic [CW-1:0] fetch_left;
    logic [CW-1:0] pkt_len;
    logic [TW-1:0] idle_timer;
    logic          in_flight;
    logic          in_flight_last;
    logic [1:0]    skid_count;
    logic [1:0]    occ;
    logic          out_fire;
    logic          full_trig;
    logic          flush_trig;

    assign full_trig  = (fifo_count >= BURST_LEN);
    assign flush_trig = (timeout != 0) && !fifo_empty && (idle_timer == TIMEOUT_CNT);
    assign pkt_len    = full_trig ? BURST_LEN : fifo_count;
    assign out_fire   = out_valid && out_ready;

    // In-flight read counts against skid space, so at most two words are ever owed downstream.
    assign occ        = skid_count + {1'b0, in_flight};
    assign fifo_rd_en = (state == FETCH) && (fetch_left != '0) && !fifo_empty &&
                        ((occ < 2'd2) || ((occ == 2'd2) && out_fire));

    fifo_skid_buf #(
        .width(width)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight),
        .push_data (fifo_data),
        .push_last (in_flight_last),
        .pop_ready (out_ready),
        .pop_valid (out_valid),
        .pop_data  (out_data),
        .pop_last  (out_last),
        .count     (skid_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            fetch_left     <= '0;
            idle_timer     <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= fifo_rd_en;
            // the word read while one remains to fetch is the packet's final word
            in_flight_last <= fifo_rd_en && (fetch_left == ONE);
            case (state)
                IDLE: begin
                    if (full_trig || flush_trig) begin
                        state      <= FETCH;
                        busy       <= 1'b1;
                        fetch_left <= pkt_len;
                        idle_timer <= '0;
                    end else if (fifo_empty) begin
                        idle_timer <= '0;
                    end else if (timeout != 0) begin
                        idle_timer <= idle_timer + TW'(1);
                    end
                end
                FETCH: begin
                    if (fifo_rd_en) begin
                        fetch_left <= fetch_left - ONE;
                        if (fetch_left == ONE)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire && out_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a queue-backed FIFO model feeds the DUT and
// a scoreboard checks every handshaken word, its framing and the stream rules.
module tb_fifo_burst_reader;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int B  = 4;
    localparam int T  = 15;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count = '0;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_rd_en;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [W-1:0] wr_log[$];
    logic [W-1:0] fq[$];
    int           wr_idx = 0;
    logic [W-1:0] exp_d[$];
    logic         exp_l[$];
    int           sb_idx = 0;
    int           rd_log[$];
    int           pop_log[$];
    int           rb, pb, rb2, pb2, c0;

    fifo_burst_reader #(
        .width(W), .depth(D), .burst(B), .timeout(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered read port; words queued in wr_log land together on the next edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fq.delete();
            wr_idx = wr_log.size();
            fifo_count <= '0;
            fifo_data  <= '0;
        end else begin
            if (fifo_rd_en && fq.size() != 0)
                fifo_data <= fq.pop_front();
            while (wr_idx < wr_log.size()) begin
                if (fq.size() < D) fq.push_back(wr_log[wr_idx]);
                wr_idx++;
            end
            fifo_count <= CW'(fq.size());
        end
    end
    assign fifo_empty = (fifo_count == '0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] base, input int n, input int period);
        for (int i = 0; i < n; i++) begin
            wr_log.push_back(base + W'(i));
            exp_d.push_back(base + W'(i));
            exp_l.push_back((i % period) == period - 1);
        end
    endtask

    task automatic wait_drain(input string tag, input int lim, input bit rnd);
        int n = 0;
        while (sb_idx != exp_d.size() && n < lim) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        check({tag, "_drain"}, exp_d.size() - sb_idx, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic monitor();
        logic         hv = 1'b0;
        logic [W-1:0] hd = '0;
        logic         hl = 1'b0;
        int           on = 0;
        forever begin
            @(negedge clk or negedge reset);
            if (!reset) begin
                sb_idx = exp_d.size();
                hv = 1'b0;
                on = 0;
            end else begin
                if (fifo_rd_en) begin
                    rd_log.push_back(cyc);
                    check("rd_while_empty", fifo_empty, 0);
                end
                if (hv) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, hd);
                    check("hold_last", out_last, hl);
                end
                if (out_valid && out_ready) begin
                    check("sb_pending", sb_idx < exp_d.size(), 1);
                    if (sb_idx < exp_d.size()) begin
                        check("sb_data", out_data, exp_d[sb_idx]);
                        check("sb_last", out_last, exp_l[sb_idx]);
                    end
                    pop_log.push_back(cyc);
                    sb_idx++;
                    on--;
                end
                if (fifo_rd_en) begin
                    on++;
                    check("outstanding_le2", on <= 2, 1);
                end
                hv = out_valid && !out_ready;
                hd = out_data;
                hl = out_last;
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset state
        repeat (3) tick();
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        tick();

        // full burst of 4 with ready held high
        rb = rd_log.size(); pb = pop_log.size();
        load(8'h10, 4, 4);
        wait_drain("burst", 40, 1'b0);
        check("burst_rd_cnt", rd_log.size() - rb, 4);
        if (rd_log.size() >= rb + 4 && pop_log.size() >= pb + 4) begin
            check("burst_rd_span", rd_log[rb+3] - rd_log[rb], 3);
            check("burst_pop_span", pop_log[pb+3] - pop_log[pb], 3);
            check("burst_latency", pop_log[pb] - rd_log[rb], 2);
        end

        // timeout flush of two words
        rb = rd_log.size();
        load(8'hA1, 2, 2);
        tick();
        c0 = cyc;
        wait_drain("timeout", 60, 1'b0);
        check("timeout_rd_cnt", rd_log.size() - rb, 2);
        if (rd_log.size() > rb)
            check("timeout_first_rd", rd_log[rb] - c0, 16);

        // backpressure: stall 10 cycles after the first word leaves
        pb = pop_log.size();
        load(8'h00, 8, 4);
        for (int n = 0; n < 40 && pop_log.size() < pb + 1; n++) tick();
        check("bp_started", pop_log.size() - pb, 1);
        out_ready = 1'b0;
        rb2 = rd_log.size(); pb2 = pop_log.size();
        repeat (10) tick();
        check("bp_stall_reads", (rd_log.size() - rb2) <= 2, 1);
        check("bp_stall_pops", pop_log.size() - pb2, 0);
        check("bp_stall_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_drain("bp", 80, 1'b0);

        // full FIFO, random backpressure
        rb = rd_log.size();
        load(8'h40, 16, 4);
        wait_drain("full", 300, 1'b1);
        check("full_rd_cnt", rd_log.size() - rb, 16);
        check("full_empty_end", fifo_empty, 1);

        // concurrent write during a packet
        load(8'h60, 4, 4);
        for (int n = 0; n < 20 && !busy; n++) tick();
        check("cw_busy", busy, 1);
        load(8'h70, 3, 3);
        wait_drain("cw", 120, 1'b0);

        // reset while draining with two words buffered
        pb = pop_log.size();
        load(8'h80, 4, 4);
        for (int n = 0; n < 40 && pop_log.size() < pb + 2; n++) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        check("mid_busy", busy, 1);
        check("mid_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", fifo_rd_en, 0);
        check("mid_rst_data", out_data, 0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        load(8'h90, 4, 4);
        wait_drain("post_rst", 40, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
